// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

  localparam int unsigned IMEM_ADDR_W    = 6;
  localparam int unsigned IMEM_DEPTH     = 64;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes into 32-bit words; flags the byte that completes a word.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byteFire,
  input  logic [7:0]  byteIn,
  output logic        wordValid_c,
  output logic [31:0] word_c
);

  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned HOLD_W = 8 * (BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]  byteCnt;
  logic [HOLD_W-1:0] hold;

  // The completing byte is merged combinationally so the top can register the whole word in one edge.
  assign wordValid_c = byteFire && (byteCnt == CNT_W'(BYTES_PER_WORD - 1));
  assign word_c      = BIG_ENDIAN ? {hold, byteIn} : {byteIn, hold};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt <= '0;
      hold    <= '0;
    end else if (clear) begin
      byteCnt <= '0;
      hold    <= '0;
    end else if (byteFire) begin
      byteCnt <= byteCnt + CNT_W'(1);
      hold    <= BIG_ENDIAN ? {hold[HOLD_W-9:0], byteIn} : {byteIn, hold[HOLD_W-1:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the CPU until a complete image is stored.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e          state;
  logic [ADDR_W:0] nWords;
  logic            fire_c;
  logic            dataFire_c;
  logic            startAcc_c;
  logic            hdrOk_c;
  logic            lastByte_c;
  logic            wordValid_c;
  logic [31:0]     word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      chkSum;
`endif

  assign fire_c     = byte_valid && byte_ready;
  assign dataFire_c = fire_c && (state == DATA);
  assign startAcc_c = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign hdrOk_c    = (byte_in != 8'd0) && (32'(byte_in) <= DEPTH);
  // The word completed now is the last one when the words already written equal N-1.
  assign lastByte_c = wordValid_c && (word_count == nWords - (ADDR_W + 1)'(1));

  imem_word_packer #(.BIG_ENDIAN(BIG_ENDIAN)) uPacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (startAcc_c),
    .byteFire    (dataFire_c),
    .byteIn      (byte_in),
    .wordValid_c (wordValid_c),
    .word_c      (word_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nWords     <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chkSum     <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (wordValid_c) begin
        we         <= 1'b1;
        wa         <= word_count[ADDR_W-1:0];
        wd         <= word_c;
        word_count <= word_count + (ADDR_W + 1)'(1);
      end
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            word_count <= '0;
            wa         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chkSum     <= '0;
`endif
          end
        end
        HDR: begin
          if (fire_c) begin
            if (hdrOk_c) begin
              nWords <= (ADDR_W + 1)'(byte_in);
              state  <= DATA;
            end else begin
              state      <= ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end
        end
        DATA: begin
          if (fire_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chkSum <= chkSum + byte_in;
            if (lastByte_c) state <= CHK;
`else
            if (lastByte_c) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (fire_c) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (8'(chkSum + byte_in) == 8'h00) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random byte streams, expected writes queued from a word-level model.
module tb_imem_loader;

  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;
  logic [AW:0]   word_count;

  typedef struct {
    int          wa;
    logic [31:0] wd;
    bit          last;
  } wr_t;

  wr_t        expQ[$];
  logic [7:0] dataQ[$];
  int         checks = 0;
  int         passed = 0;

  imem_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && we) begin
      chk("we_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("wa", 32'(wa), 32'(e.wa));
        chk("wd", wd, e.wd);
        chk("word_count_at_we", 32'(word_count), 32'(e.wa + 1));
        if (e.last) begin
          chk("done_with_last_we", 32'(done), 32'd1);
          chk("hold_with_last_we", 32'(cpu_hold), 32'd0);
        end
      end
    end
  end

  task automatic checkResetVals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_wa"}, 32'(wa), 32'd0);
    chk({tag, "_wd"}, wd, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  // mode 0: continuous, 1: one idle cycle before every byte, 2: random 0..3 idle cycles
  task automatic sendByte(input logic [7:0] b, input int mode);
    int stalls;
    int t;
    stalls = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 3)) : 0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
    end
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("ready_timeout", 32'(byte_ready), 32'd1);
  endtask

  task automatic endStream();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fillRandom(input int n);
    dataQ.delete();
    for (int i = 0; i < 4 * n; i++) dataQ.push_back(8'($urandom));
  endtask

  task automatic fillDirected();
    dataQ = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  endtask

  // Reference model: header validity, big-endian word assembly and mod-256 checksum from the stream rules.
  task automatic runLoad(input int hdr, input int mode, input bit badChk);
    bit         valid;
    bit         expOk;
    logic [7:0] sum;
    wr_t        e;
    int         t;
    valid = (hdr >= 1) && (hdr <= (1 << AW));
    sum   = 8'h00;
    if (valid) begin
      for (int w = 0; w < hdr; w++) begin
        e.wa = w;
        e.wd = (32'(dataQ[4*w]) << 24) | (32'(dataQ[4*w+1]) << 16) |
               (32'(dataQ[4*w+2]) << 8) | 32'(dataQ[4*w+3]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        e.last = 1'b0;
`else
        e.last = (w == hdr - 1);
`endif
        expQ.push_back(e);
      end
      for (int i = 0; i < 4 * hdr; i++) sum = sum + dataQ[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    expOk = valid && !badChk;
`else
    expOk = valid;
`endif
    pulseStart();
    chk("start_clears_done", 32'(done), 32'd0);
    chk("start_sets_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(byte_ready), 32'd1);
    sendByte(8'(hdr), mode);
    if (valid) begin
      for (int i = 0; i < 4 * hdr; i++) sendByte(dataQ[i], mode);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendByte(8'(8'h00 - sum) + 8'(badChk), mode);
`endif
    end
    endStream();
    t = 0;
    while (!(done || error) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("finish_timeout", 32'(t < 500), 32'd1);
    @(negedge clk);
    chk("done", 32'(done), 32'(expOk));
    chk("error", 32'(error), 32'(!expOk));
    chk("cpu_hold", 32'(cpu_hold), 32'(!expOk));
    chk("busy_end", 32'(busy), 32'd0);
    chk("ready_end", 32'(byte_ready), 32'd0);
    chk("word_count_end", 32'(word_count), valid ? 32'(hdr) : 32'd0);
    if (valid) chk("last_wa", 32'(wa), 32'(hdr - 1));
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    checkResetVals("reset");
    rst_n = 1'b1;

    fillDirected();
    runLoad(2, 0, 1'b0);
    fillDirected();
    runLoad(2, 1, 1'b0);

    runLoad(0, 0, 1'b0);
    runLoad(8'h41, 0, 1'b0);

    fillRandom(64);
    runLoad(64, 2, 1'b0);

    // Abort mid-load: only the first word reaches memory, then reset clears everything.
    fillRandom(2);
    begin
      wr_t e;
      e.wa   = 0;
      e.wd   = {dataQ[0], dataQ[1], dataQ[2], dataQ[3]};
      e.last = 1'b0;
      expQ.push_back(e);
    end
    pulseStart();
    sendByte(8'd2, 0);
    for (int i = 0; i < 5; i++) sendByte(dataQ[i], 0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("abort_first_word_written", 32'(expQ.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    checkResetVals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    fillDirected();
    runLoad(2, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 24));
      fillRandom(n);
      runLoad(n, 2, 1'b0);
    end
    runLoad(int'($urandom_range(65, 255)), 2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    fillDirected();
    runLoad(2, 0, 1'b1);
    fillRandom(5);
    runLoad(5, 2, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
